// File: rtl/cosine_pkg.sv
// Shared constants for the cosine lookup, plus an elaboration-time generator
// that builds each binary64 table entry from exact fixed-point arithmetic.
package cosine_pkg;

  localparam int COS_DATA_WIDTH = 32;
  localparam int LUT_DEPTH      = 91;
  localparam int MAX_ANGLE      = 90;

  localparam logic [63:0] FP64_ZERO = 64'h0000000000000000;
  localparam logic [63:0] FP64_ONE  = 64'h3FF0000000000000;
  localparam logic [63:0] FP64_HALF = 64'h3FE0000000000000;
  localparam logic [63:0] FP64_QNAN = 64'h7FF8000000000000;

  localparam int FX_FRAC = 128;
  localparam int FX_W    = 272;
  typedef logic [FX_W-1:0] fx_t;

  localparam fx_t FX_ONE = fx_t'(1) << FX_FRAC;
  localparam fx_t FX_PI  = 272'h3_243F6A88_85A308D3_13198A2E_03707344;

  // cos(k deg) as binary64, round-to-nearest-even. The Taylor sum runs in
  // Q?.128 fixed point, far below the 2^-53 rounding granularity.
  function automatic logic [63:0] cos_deg_fp64(input int k);
    fx_t         x, x2, term, pos, neg, c, mask;
    logic [52:0] mant;
    logic [10:0] expo;
    logic        guard, sticky;
    int          p;
    if (k == 0)          return FP64_ONE;
    if (k == 60)         return FP64_HALF;
    if (k >= MAX_ANGLE)  return FP64_ZERO;
    x    = (FX_PI * fx_t'(k)) / fx_t'(180);
    x2   = (x * x) >> FX_FRAC;
    term = FX_ONE;
    pos  = FX_ONE;
    neg  = '0;
    for (int n = 1; n <= 24; n++) begin
      term = ((term * x2) >> FX_FRAC) / fx_t'((2 * n - 1) * (2 * n));
      if (n % 2 == 1) neg = neg + term;
      else            pos = pos + term;
    end
    c = pos - neg;
    p = 0;
    for (int b = 0; b <= FX_FRAC; b++) begin
      if (((c >> b) & fx_t'(1)) != '0) p = b;
    end
    expo   = 11'(895 + p);
    mant   = 53'((c >> (p - 52)) & ((fx_t'(1) << 52) - fx_t'(1)));
    guard  = ((c >> (p - 53)) & fx_t'(1)) != '0;
    mask   = (fx_t'(1) << (p - 53)) - fx_t'(1);
    sticky = (c & mask) != '0;
    if (guard && (sticky || mant[0])) mant = mant + 53'd1;
    if (mant[52]) begin
      mant = '0;
      expo = expo + 11'd1;
    end
    return {1'b0, expo, mant[51:0]};
  endfunction

endpackage

// File: rtl/cosine_rom.sv
// Combinational 91-entry binary64 table of cos(k deg), k = 0..90; indices
// beyond the table read as +0.
module cosine_rom
  import cosine_pkg::*;
(
  input  logic [6:0]  i_index,
  output logic [63:0] o_value
);

  logic [63:0] w_table [LUT_DEPTH];

  for (genvar k = 0; k < LUT_DEPTH; k++) begin : g_entry
    localparam logic [63:0] ENTRY = cos_deg_fp64(k);
    assign w_table[k] = ENTRY;
  end

  always_comb begin
    o_value = FP64_ZERO;
    if (i_index < 7'(LUT_DEPTH)) o_value = w_table[i_index];
  end

endmodule

// File: rtl/cosine_lut.sv
// Registered binary64 cosine from quadrant + reference angle (1-cycle latency).
// Define COSINE_RANGE_CHECK_EN to return quiet NaN for angles above 90 instead of clamping.
module cosine_lut
  import cosine_pkg::*;
#(
  parameter int DATA_WIDTH = COS_DATA_WIDTH
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    en_cosine,
  input  logic [1:0]              quadrant,
  input  logic [DATA_WIDTH-1:0]   data_in,
  output logic [2*DATA_WIDTH-1:0] data_out
);

  localparam int OUT_W = 2 * DATA_WIDTH;

  logic                 w_in_range;
  logic                 w_neg;
  logic [6:0]           w_index;
  logic [63:0]          w_rom_value;
  logic [63:0]          w_result;
  logic [OUT_W-1:0]     r_data_out_p1;

  function automatic logic [6:0] saturate_index(input logic [DATA_WIDTH-1:0] angle,
                                                input logic in_range);
    return in_range ? angle[6:0] : 7'(MAX_ANGLE);
  endfunction

  // A zero magnitude keeps its + sign so -0 never leaves the block.
  function automatic logic [63:0] apply_sign(input logic [63:0] mag, input logic neg);
    return (neg && (mag != FP64_ZERO)) ? (mag | 64'h8000000000000000) : mag;
  endfunction

  assign w_in_range = (data_in <= DATA_WIDTH'(MAX_ANGLE));
  assign w_neg      = quadrant[0] ^ quadrant[1];
  assign w_index    = saturate_index(data_in, w_in_range);

  cosine_rom u_rom (
    .i_index (w_index),
    .o_value (w_rom_value)
  );

`ifdef COSINE_RANGE_CHECK_EN
  assign w_result = w_in_range ? apply_sign(w_rom_value, w_neg) : FP64_QNAN;
`else
  assign w_result = apply_sign(w_rom_value, w_neg);
`endif

  // Stage p0 -> p1: single output register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)       r_data_out_p1 <= '0;
    else if (en_cosine) r_data_out_p1 <= OUT_W'(w_result);
  end

  assign data_out = r_data_out_p1;

endmodule

// File: tb/tb_cosine_lut.sv
// Directed bench for cosine_lut: reset, full sweep, sign handling, hold and range behaviour.
module tb_cosine_lut;

  localparam real PI_R = 3.14159265358979323846;
`ifdef COSINE_RANGE_CHECK_EN
  localparam logic [63:0] OOR_EXP = 64'h7FF8000000000000;
`else
  localparam logic [63:0] OOR_EXP = 64'h0000000000000000;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        en_cosine = 1'b0;
  logic [1:0]  quadrant = 2'd0;
  logic [31:0] data_in = 32'd0;
  logic [63:0] data_out;

  int n_assert = 0;
  int n_fail   = 0;

  cosine_lut #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .en_cosine (en_cosine),
    .quadrant  (quadrant),
    .data_in   (data_in),
    .data_out  (data_out)
  );

  always #5 clk = ~clk;

  task automatic check64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic en, input logic [1:0] q, input logic [31:0] d);
    @(negedge clk);
    en_cosine = en;
    quadrant  = q;
    data_in   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [63:0] prev;
    real got, want, diff;

    // reset held with enable active
    en_cosine = 1'b1;
    data_in   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check64("reset_initial", data_out, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check64("first_after_reset", data_out, 64'h3FF0000000000000);

    // sweep quadrant 0
    prev = 64'h7FF0000000000000;
    for (int k = 0; k <= 90; k++) begin
      step(1'b1, 2'd0, 32'(k));
      got  = $bitstoreal(data_out);
      want = $cos(real'(k) * PI_R / 180.0);
      diff = (got > want) ? (got - want) : (want - got);
      n_assert++;
      assert (diff <= 4.0e-16) else begin
        n_fail++;
        $error("FAIL sweep_k%0d: observed %h (%e) expected about %e", k, data_out, got, want);
      end
      n_assert++;
      assert (data_out < prev) else begin
        n_fail++;
        $error("FAIL monotonic_k%0d: observed %h expected below %h", k, data_out, prev);
      end
      prev = data_out;
      if (k == 0)  check64("spot_0",  data_out, 64'h3FF0000000000000);
      if (k == 45) check64("spot_45", data_out, 64'h3FE6A09E667F3BCD);
      if (k == 60) check64("spot_60", data_out, 64'h3FE0000000000000);
      if (k == 90) check64("spot_90", data_out, 64'h0000000000000000);
    end

    // quadrant sign handling
    step(1'b1, 2'd1, 32'd60);  check64("q1_60", data_out, 64'hBFE0000000000000);
    step(1'b1, 2'd2, 32'd0);   check64("q2_0",  data_out, 64'hBFF0000000000000);
    step(1'b1, 2'd3, 32'd60);  check64("q3_60", data_out, 64'h3FE0000000000000);
    step(1'b1, 2'd3, 32'd45);  check64("q3_45", data_out, 64'h3FE6A09E667F3BCD);
    step(1'b1, 2'd2, 32'd45);  check64("q2_45", data_out, 64'hBFE6A09E667F3BCD);
    step(1'b1, 2'd1, 32'd90);  check64("q1_90_poszero", data_out, 64'h0);
    step(1'b1, 2'd2, 32'd90);  check64("q2_90_poszero", data_out, 64'h0);

    // hold while disabled
    step(1'b1, 2'd1, 32'd60);  check64("hold_load", data_out, 64'hBFE0000000000000);
    step(1'b0, 2'd0, 32'd10);  check64("hold_1", data_out, 64'hBFE0000000000000);
    step(1'b0, 2'd2, 32'd0);   check64("hold_2", data_out, 64'hBFE0000000000000);
    step(1'b0, 2'd3, 32'd89);  check64("hold_3", data_out, 64'hBFE0000000000000);
    step(1'b1, 2'd0, 32'd0);   check64("resume", data_out, 64'h3FF0000000000000);

    // out-of-range angles
    step(1'b1, 2'd1, 32'd200); check64("oor_200_q1", data_out, OOR_EXP);
    step(1'b1, 2'd0, 32'd0);   check64("oor_reload", data_out, 64'h3FF0000000000000);
    step(1'b1, 2'd0, 32'd91);  check64("oor_91_q0", data_out, OOR_EXP);
    step(1'b1, 2'd3, 32'hFFFF_FFFF); check64("oor_max_q3", data_out, OOR_EXP);

    // asynchronous reset mid-stream
    step(1'b1, 2'd0, 32'd0);   check64("pre_reset", data_out, 64'h3FF0000000000000);
    #2;
    reset_n = 1'b0;
    #1;
    check64("reset_async", data_out, 64'h0);
    @(posedge clk);
    #1;
    check64("reset_hold_1", data_out, 64'h0);
    @(negedge clk);
    data_in = 32'd45;
    @(posedge clk);
    #1;
    check64("reset_hold_2", data_out, 64'h0);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    check64("reset_release", data_out, 64'h3FE6A09E667F3BCD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
